main_mem_responder: RTL and testbench

Synthesizable main-memory responder for the cache controller's main-memory interface. It is the slave end of the main_mem_* request/ready handshake.
- Read: accepts a block read request and returns a full 512-bit block after a fixed latency.
- Write: accepts a write-through single-word request and commits that 32-bit lane into the addressed block.
- Replaces the behavioural DRAM model in system-level simulation and serves as the FPGA-side memory stub.

---
 rtl/mem_if_pkg.sv | 28 ++
 rtl/mem_block_ram.sv | 68 ++++++
 rtl/main_mem_responder.sv | 152 +++++++++++++++
 tb/tb_main_mem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the cache controller's main-memory interface:
// bus widths, block/word geometry, responder state and operation encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_if_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned BLOCK_W         = 512;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned OFFSET_BITS     = 6;
    localparam int unsigned WORDS_PER_BLOCK = BLOCK_W / WORD_W;
    localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage : mem_if_pkg

// File: rtl/mem_block_ram.sv
// -----------------------------------------------------------------------------
// mem_block_ram
// Single-port DEPTH_BLOCKS x BLOCK_W block store with a synchronous full-block
// read port and per-word write enables. Block i powers up holding the value i
// (zero-extended); the array itself is never reset.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   async active-high reset (clears the read-data register only)
//   i_addr     in   block index
//   i_rd_en    in   capture mem[i_addr] into the read-data register
//   i_wr_en    in   one bit per 32-bit word lane of the addressed block
//   i_wr_data  in   word written into every enabled lane
//   o_rd_data  out  registered read block, held until the next read
// -----------------------------------------------------------------------------
module mem_block_ram
    import mem_if_pkg::*;
#(
    parameter  int unsigned DEPTH_BLOCKS = 1024,
    localparam int unsigned BLK_W        = $clog2(DEPTH_BLOCKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BLK_W-1:0]           i_addr,
    input  logic                       i_rd_en,
    input  logic [WORDS_PER_BLOCK-1:0] i_wr_en,
    input  logic [WORD_W-1:0]          i_wr_data,
    output logic [BLOCK_W-1:0]         o_rd_data
);

    logic [BLOCK_W-1:0] r_mem [DEPTH_BLOCKS];
    logic [BLOCK_W-1:0] r_rd_data;
    logic [BLOCK_W-1:0] w_wr_mask;
    logic [BLOCK_W-1:0] w_wr_block;

    // Power-up image: block i holds i.
    initial begin
        for (int unsigned i = 0; i < DEPTH_BLOCKS; i++) begin
            r_mem[i] = BLOCK_W'(i);
        end
    end

    // Lane enables expanded to a bit mask so the write is one merge of the
    // replicated word into the addressed block.
    for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_mask
        assign w_wr_mask[g*WORD_W +: WORD_W] = {WORD_W{i_wr_en[g]}};
    end

    assign w_wr_block = (r_mem[i_addr] & ~w_wr_mask)
                      | ({WORDS_PER_BLOCK{i_wr_data}} & w_wr_mask);

    always_ff @(posedge clk) begin
        if (|i_wr_en) begin
            r_mem[i_addr] <= w_wr_block;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : mem_block_ram

// File: rtl/main_mem_responder.sv
// -----------------------------------------------------------------------------
// main_mem_responder
// Slave end of the cache controller's main_mem_* request/ready handshake.
// A block read returns the full 512-bit block; a write-through request commits
// one 32-bit lane. Each accepted request completes LATENCY+1 edges after
// acceptance with a single-cycle ready pulse. Requests arriving while a
// transaction is in flight are dropped, not queued.
//
// Ports:
//   clk                 in   clock, rising edge
//   rst                 in   async active-high reset (aborts any transaction)
//   main_mem_addr       in   request byte address
//   main_mem_data_out   in   write word from controller
//   main_mem_read_req   in   block read request (level)
//   main_mem_write_req  in   word write request (level, wins over read)
//   main_mem_data_in    out  last read block, held until the next read
//   main_mem_ready      out  one-cycle completion pulse
//   busy                out  high while in BUSY or DONE
// -----------------------------------------------------------------------------
module main_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH_BLOCKS = 1024,
    parameter int unsigned LATENCY      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  main_mem_addr,
    input  logic [WORD_W-1:0]  main_mem_data_out,
    input  logic               main_mem_read_req,
    input  logic               main_mem_write_req,
    output logic [BLOCK_W-1:0] main_mem_data_in,
    output logic               main_mem_ready,
    output logic               busy
);

    localparam int unsigned BLK_W = $clog2(DEPTH_BLOCKS);

    if (LATENCY > 65535) begin : g_bad_latency
        $error("main_mem_responder: LATENCY must fit the 16-bit wait counter");
    end
    if (DEPTH_BLOCKS < 2 || (DEPTH_BLOCKS & (DEPTH_BLOCKS - 1)) != 0) begin : g_bad_depth
        $error("main_mem_responder: DEPTH_BLOCKS must be a power of two >= 2");
    end
    if (OFFSET_BITS + BLK_W >= ADDR_W) begin : g_bad_geom
        $error("main_mem_responder: block index does not fit the address");
    end

    state_t                  r_state;
    op_t                     r_op;
    logic [CNT_W-1:0]        r_cnt;
    logic [BLK_W-1:0]        r_blk;
    logic [WORD_IDX_W-1:0]   r_word;
    logic [WORD_W-1:0]       r_wdata;
    logic                    r_ready;
    logic                    r_busy;

    logic [BLK_W-1:0]           w_blk;
    logic [WORD_IDX_W-1:0]      w_word;
    logic                       w_do_op;
    logic                       w_rd_en;
    logic [WORDS_PER_BLOCK-1:0] w_wr_en;
    logic [BLOCK_W-1:0]         w_rd_data;
    logic                       w_unused;

    // Upper address bits wrap (modulo depth); byte-in-word bits are ignored.
    assign w_blk    = main_mem_addr[OFFSET_BITS +: BLK_W];
    assign w_word   = main_mem_addr[2 +: WORD_IDX_W];
    assign w_unused = ^{main_mem_addr[ADDR_W-1:OFFSET_BITS+BLK_W], main_mem_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_READ;
            r_cnt   <= '0;
            r_blk   <= '0;
            r_word  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    if (main_mem_write_req) begin
                        r_op    <= OP_WRITE;
                        r_blk   <= w_blk;
                        r_word  <= w_word;
                        r_wdata <= main_mem_data_out;
                        r_cnt   <= CNT_W'(LATENCY);
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end else if (main_mem_read_req) begin
                        r_op    <= OP_READ;
                        r_blk   <= w_blk;
                        r_cnt   <= CNT_W'(LATENCY);
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The RAM acts on the same edge that moves BUSY->DONE, so its read
    // register and the ready pulse update together. Reset forces IDLE
    // asynchronously, which also drops any pending write enable.
    assign w_do_op = (r_state == BUSY) && (r_cnt == '0);
    assign w_rd_en = w_do_op && (r_op == OP_READ);

    always_comb begin
        w_wr_en = '0;
        if (w_do_op && (r_op == OP_WRITE)) begin
            w_wr_en[r_word] = 1'b1;
        end
    end

    mem_block_ram #(
        .DEPTH_BLOCKS (DEPTH_BLOCKS)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (r_blk),
        .i_rd_en   (w_rd_en),
        .i_wr_en   (w_wr_en),
        .i_wr_data (r_wdata),
        .o_rd_data (w_rd_data)
    );

    assign main_mem_data_in = w_rd_data;
    assign main_mem_ready   = r_ready;
    assign busy             = r_busy;

endmodule : main_mem_responder

// File: tb/tb_main_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_main_mem_responder
// Scoreboard bench: each accepted request pushes the data_in value expected at
// its ready pulse; a negedge monitor pops and compares on every pulse.
// -----------------------------------------------------------------------------
module tb_main_mem_responder;
    import mem_if_pkg::*;

    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 1024;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  main_mem_addr;
    logic [WORD_W-1:0]  main_mem_data_out;
    logic               main_mem_read_req;
    logic               main_mem_write_req;
    logic [BLOCK_W-1:0] main_mem_data_in;
    logic               main_mem_ready;
    logic               busy;

    always #5 clk = ~clk;

    main_mem_responder #(
        .DEPTH_BLOCKS (DEPTH),
        .LATENCY      (LAT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .main_mem_addr      (main_mem_addr),
        .main_mem_data_out  (main_mem_data_out),
        .main_mem_read_req  (main_mem_read_req),
        .main_mem_write_req (main_mem_write_req),
        .main_mem_data_in   (main_mem_data_in),
        .main_mem_ready     (main_mem_ready),
        .busy               (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;
    int last_pulse_cyc = 0;
    int req_cyc  = 0;
    logic prev_ready = 1'b0;

    logic [BLOCK_W-1:0] sb_q [$];
    logic [BLOCK_W-1:0] model [int];
    logic [BLOCK_W-1:0] last_rd = '0;

    task automatic check(input string tag, input logic [BLOCK_W-1:0] got,
                         input logic [BLOCK_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BLOCK_W-1:0] exp_block(input int unsigned blk);
        if (model.exists(int'(blk))) return model[int'(blk)];
        return BLOCK_W'(blk);
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (main_mem_ready === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
            check("ready_width", BLOCK_W'(prev_ready), BLOCK_W'(0));
            check("sb_nonempty", BLOCK_W'(sb_q.size() > 0), BLOCK_W'(1));
            if (sb_q.size() > 0) begin
                check("data_in", main_mem_data_in, sb_q.pop_front());
            end
        end
        prev_ready = main_mem_ready;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present one request for a single sampling edge; 'track' records the
    // expected outcome in the model and scoreboard.
    task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input bit track);
        int unsigned blk  = (addr >> OFFSET_BITS) % DEPTH;
        int unsigned widx = int'(addr[5:2]);
        logic [BLOCK_W-1:0] b;
        main_mem_addr      = addr;
        main_mem_data_out  = data;
        main_mem_write_req = wr;
        main_mem_read_req  = rd;
        if (track) begin
            if (wr) begin
                b = exp_block(blk);
                b[widx*WORD_W +: WORD_W] = data;
                model[int'(blk)] = b;
                sb_q.push_back(last_rd);
            end else if (rd) begin
                last_rd = exp_block(blk);
                sb_q.push_back(last_rd);
            end
        end
        step();
        req_cyc = cyc;
        main_mem_write_req = 1'b0;
        main_mem_read_req  = 1'b0;
        main_mem_data_out  = ~data;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (pulses < target && n < budget) begin
            step();
            n++;
        end
        check("pulse_wait", BLOCK_W'(pulses), BLOCK_W'(target));
    endtask

    task automatic run(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data);
        int p0 = pulses;
        issue(wr, rd, addr, data, 1'b1);
        wait_pulses(p0 + 1, 40);
        check("latency", BLOCK_W'(last_pulse_cyc - req_cyc), BLOCK_W'(LAT + 1));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int first_cyc;
        rst                = 1'b1;
        main_mem_addr      = '0;
        main_mem_data_out  = '0;
        main_mem_read_req  = 1'b0;
        main_mem_write_req = 1'b0;
        repeat (3) step();
        check("rst_ready", BLOCK_W'(main_mem_ready), BLOCK_W'(0));
        check("rst_busy", BLOCK_W'(busy), BLOCK_W'(0));
        check("rst_data", main_mem_data_in, BLOCK_W'(0));
        rst = 1'b0;
        step();

        // 1: read latency and busy window
        p0 = pulses;
        issue(1'b0, 1'b1, 32'h0000_1000, 32'h0, 1'b1);
        check("t1_busy_N", BLOCK_W'(busy), BLOCK_W'(1));
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t1_busy", BLOCK_W'(busy), BLOCK_W'(1));
            check("t1_ready", BLOCK_W'(main_mem_ready), BLOCK_W'(k == 4));
        end
        check("t1_latency", BLOCK_W'(last_pulse_cyc - req_cyc), BLOCK_W'(LAT + 1));
        check("t1_data", main_mem_data_in, BLOCK_W'(64));
        step();
        check("t1_busy_end", BLOCK_W'(busy), BLOCK_W'(0));
        check("t1_pulses", BLOCK_W'(pulses - p0), BLOCK_W'(1));

        // 2: single-lane write, data latched at acceptance
        run(1'b1, 1'b0, 32'h0000_2004, 32'hCAFE_BABE);
        run(1'b0, 1'b1, 32'h0000_2000, 32'h0);
        check("t2_word1", BLOCK_W'(main_mem_data_in[63:32]), BLOCK_W'(32'hCAFE_BABE));
        check("t2_word0", BLOCK_W'(main_mem_data_in[31:0]), BLOCK_W'(32'h80));

        // 3: write wins when both requests are high
        run(1'b1, 1'b1, 32'h0000_3000, 32'h1234_5678);
        run(1'b0, 1'b1, 32'h0000_3000, 32'h0);

        // 4: request during BUSY dropped; request held through DONE served
        p0 = pulses;
        issue(1'b0, 1'b1, 32'h0000_1000, 32'h0, 1'b1);
        step();
        main_mem_addr     = 32'h0004_1000;
        main_mem_read_req = 1'b1;
        step();
        main_mem_read_req = 1'b0;
        step();
        main_mem_read_req = 1'b1;
        last_rd = exp_block(64);
        sb_q.push_back(last_rd);
        wait_pulses(p0 + 1, 20);
        first_cyc = last_pulse_cyc;
        step();
        step();
        main_mem_read_req = 1'b0;
        wait_pulses(p0 + 2, 20);
        check("t4_spacing", BLOCK_W'(last_pulse_cyc - first_cyc), BLOCK_W'(LAT + 3));
        repeat (10) step();
        check("t4_pulses", BLOCK_W'(pulses - p0), BLOCK_W'(2));

        // 5: out-of-range block index wraps
        run(1'b0, 1'b1, 32'h0001_0000, 32'h0);
        run(1'b0, 1'b1, 32'h0001_0040, 32'h0);

        // 6: reset during BUSY aborts the write
        p0 = pulses;
        issue(1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_rd = '0;
        check("t6_data_rst", main_mem_data_in, BLOCK_W'(0));
        check("t6_busy_rst", BLOCK_W'(busy), BLOCK_W'(0));
        repeat (8) step();
        check("t6_no_ready", BLOCK_W'(pulses - p0), BLOCK_W'(0));
        run(1'b0, 1'b1, 32'h0000_1000, 32'h0);

        repeat (4) step();
        check("sb_drain", BLOCK_W'(sb_q.size()), BLOCK_W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_main_mem_responder
